bus_tenure_arbiter: RTL

BUS_TENURE_ARBITER -- requirements
Module: bus_tenure_arbiter

---
 rtl/bus_tenure_arbiter.sv | 130 +++++++++++++
 1 files changed

// File: rtl/bus_tenure_arbiter.sv
// Four-master round-robin bus arbiter with tenure limit and preemption.
// Requests and grants are active-low; a one-cycle handover gap separates tenures.
module bus_tenure_arbiter #(
   parameter int MAX_TENURE = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       m0_req_,
   input  logic       m1_req_,
   input  logic       m2_req_,
   input  logic       m3_req_,
   output logic       m0_grnt_,
   output logic       m1_grnt_,
   output logic       m2_grnt_,
   output logic       m3_grnt_,
   output logic [1:0] owner,
   output logic       bus_idle,
   output logic       preempt
);

   typedef enum logic [1:0] {IDLE, GRANT, HANDOVER} state_t;

   state_t      state_reg, state_next;
   logic [1:0]  owner_reg, owner_next;
   logic [7:0]  tenure_reg, tenure_next;
   logic        preempt_reg, preempt_next;
   logic [3:0]  grnt_reg, grnt_next;

   logic [3:0]  req;
   logic [3:0]  owner_mask;
   logic [1:0]  rot_idx [4];
   logic [3:0]  rot_req;
   logic [1:0]  sel;
   logic        any_req;
   logic        other_req;
   logic        owner_req;

   assign req        = ~{m3_req_, m2_req_, m1_req_, m0_req_};
   assign owner_mask = 4'b0001 << owner_reg;
   assign any_req    = |req;
   assign other_req  = |(req & ~owner_mask);
   assign owner_req  = req[owner_reg];

   // Candidates in rotation order, starting just after the last owner.
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_rot
         assign rot_idx[gi] = owner_reg + 2'(gi + 1);
         assign rot_req[gi] = req[rot_idx[gi]];
      end
   endgenerate

   always_comb begin
      sel = owner_reg;
      if (rot_req[0])      sel = rot_idx[0];
      else if (rot_req[1]) sel = rot_idx[1];
      else if (rot_req[2]) sel = rot_idx[2];
      else if (rot_req[3]) sel = rot_idx[3];
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_reg   <= IDLE;
         owner_reg   <= 2'd3;
         tenure_reg  <= 8'd0;
         preempt_reg <= 1'b0;
         grnt_reg    <= 4'hF;
      end else begin
         state_reg   <= state_next;
         owner_reg   <= owner_next;
         tenure_reg  <= tenure_next;
         preempt_reg <= preempt_next;
         grnt_reg    <= grnt_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      owner_next   = owner_reg;
      tenure_next  = tenure_reg;
      preempt_next = 1'b0;
      case (state_reg)
         IDLE: begin
            if (any_req) begin
               state_next  = GRANT;
               owner_next  = sel;
               tenure_next = 8'd0;
            end
         end
         GRANT: begin
            if (!owner_req) begin
               state_next = other_req ? HANDOVER : IDLE;
            end else if (tenure_reg == 8'(MAX_TENURE - 1)) begin
               // Saturated: only give up the bus if someone else is waiting.
               if (other_req) begin
                  state_next   = HANDOVER;
                  preempt_next = 1'b1;
               end
            end else begin
               tenure_next = tenure_reg + 8'd1;
            end
         end
         HANDOVER: begin
            if (any_req) begin
               state_next  = GRANT;
               owner_next  = sel;
               tenure_next = 8'd0;
            end else begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      grnt_next = 4'hF;
      if (state_next == GRANT)
         grnt_next = ~(4'b0001 << owner_next);
   end

   assign m0_grnt_ = grnt_reg[0];
   assign m1_grnt_ = grnt_reg[1];
   assign m2_grnt_ = grnt_reg[2];
   assign m3_grnt_ = grnt_reg[3];
   assign owner    = owner_reg;
   assign preempt  = preempt_reg;
   assign bus_idle = (state_reg != GRANT);

endmodule
